// File: rtl/rx_pkg.sv
// Shared definitions for the UART receive path (rx_timer and rcu).
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } rx_timer_state_t;

    // Default serial frame: 10 clocks per bit, sampled mid-bit, 8 data bits + 1 stop bit.
    localparam int UART_CLKS_PER_BIT    = 10;
    localparam int UART_SAMPLE_POINT    = 5;
    localparam int UART_BITS_PER_PACKET = 9;

    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit + 1);
    endfunction

    function automatic int bit_width(input int bits_per_packet);
        return $clog2(bits_per_packet + 1);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that rolls over from rollover_val back to 1.
// rollover_flag is high while the count sits at rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Next count: clear wins, otherwise advance and wrap to 1 after rollover_val.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rx_timer.sv
// UART receive bit timer: counts clocks within a bit and bits within a packet,
// skips the start bit, strobes the shift register at the sample point of every
// following bit and pulses packet_done once the stop bit has been strobed.
//
// Optional feature macro: RX_TIMER_RUNTIME_CFG_EN adds cfg_clks_per_bit, captured
// at packet start (clamped to >= 2), with the sample point at half the period.
//
// state | meaning
// IDLE  | waiting for enable_timer; counters cleared
// COUNT | timing bits of a packet; strobes from bit 1 onward
// DONE  | stop bit strobed; counters frozen until enable_timer drops
module rx_timer
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT    = UART_CLKS_PER_BIT,
    parameter int SAMPLE_POINT    = UART_SAMPLE_POINT,
    parameter int BITS_PER_PACKET = UART_BITS_PER_PACKET
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 enable_timer,
`ifdef RX_TIMER_RUNTIME_CFG_EN
    input  logic [cnt_width(CLKS_PER_BIT)-1:0]   cfg_clks_per_bit,
`endif
    output logic                                 shift_strobe,
    output logic                                 packet_done
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = bit_width(BITS_PER_PACKET);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("rx_timer: CLKS_PER_BIT must be >= 2");
    end
    if (SAMPLE_POINT < 1 || SAMPLE_POINT > CLKS_PER_BIT) begin : g_bad_sample
        $error("rx_timer: SAMPLE_POINT must be in 1..CLKS_PER_BIT");
    end
    if (BITS_PER_PACKET < 1) begin : g_bad_bits
        $error("rx_timer: BITS_PER_PACKET must be >= 1");
    end

    rx_timer_state_t state_q;
    rx_timer_state_t state_d;
    logic            packet_done_q;
    logic            packet_done_d;

    logic [CNT_W-1:0] clk_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic             clk_roll;
    logic             bit_last;
    logic             cnt_clear;
    logic             cnt_en;
    logic             bit_en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] sample_pt;
    logic             strobe;

`ifdef RX_TIMER_RUNTIME_CFG_EN
    logic [CNT_W-1:0] cfg_q;
    logic [CNT_W-1:0] cfg_d;

    // Bit period captured when a packet starts, held for the whole packet.
    always_comb begin
        cfg_d = cfg_q;
        if (state_q == IDLE && enable_timer) begin
            cfg_d = (cfg_clks_per_bit < CNT_W'(2)) ? CNT_W'(2) : cfg_clks_per_bit;
        end
    end

    // Captured period register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cfg_q <= CNT_W'(CLKS_PER_BIT);
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign period    = cfg_q;
    assign sample_pt = cfg_q >> 1;
`else
    assign period    = CNT_W'(CLKS_PER_BIT);
    assign sample_pt = CNT_W'(SAMPLE_POINT);
`endif

    // Counters restart from zero whenever enable drops and stand still in DONE.
    // The IDLE->COUNT edge advances the clock counter 0->1, giving clk_cnt=1, bit_idx=0.
    assign cnt_clear = !enable_timer;
    assign cnt_en    = enable_timer && (state_q != DONE);
    assign bit_en    = cnt_en && (state_q == COUNT) && clk_roll;

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_clk_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (period),
        .count_out     (clk_cnt),
        .rollover_flag (clk_roll)
    );

    flex_counter #(
        .NUM_CNT_BITS (BIT_W)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (bit_en),
        .rollover_val  (BIT_W'(BITS_PER_PACKET)),
        .count_out     (bit_idx),
        .rollover_flag (bit_last)
    );

    // Strobe decoded from registered values only; bit 0 is the start bit and is skipped.
    assign strobe = (state_q == COUNT) && (clk_cnt == sample_pt) && (bit_idx != '0);

    // Next-state logic; packet_done fires only on the COUNT->DONE transition.
    always_comb begin
        state_d       = state_q;
        packet_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_timer) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!enable_timer) begin
                    state_d = IDLE;
                end else if (strobe && bit_last) begin
                    state_d       = DONE;
                    packet_done_d = 1'b1;
                end
            end
            DONE: begin
                if (!enable_timer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and packet_done registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            packet_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            packet_done_q <= packet_done_d;
        end
    end

    assign shift_strobe = strobe;
    assign packet_done  = packet_done_q;

endmodule

// File: tb/tb_rx_timer.sv
// Bench for rx_timer: default configuration plus a minimal 2/2/1 configuration.
// The reference model tracks k, the number of clocks since the edge that first
// sampled enable high, and derives the expected outputs arithmetically from k.
module tb_rx_timer;

    localparam int C1 = 10;
    localparam int S1 = 5;
    localparam int B1 = 9;
    localparam int C2 = 2;
    localparam int S2 = 2;
    localparam int B2 = 1;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic en1   = 1'b0;
    logic en2   = 1'b0;
    logic strobe1;
    logic done1;
    logic strobe2;
    logic done2;

    int checks   = 0;
    int failures = 0;
    int k1 = -1;
    int k2 = -1;
    int sq1[$];
    int dq1[$];
    int sq2[$];
    int dq2[$];

    always #5 clk = ~clk;

    rx_timer #(
        .CLKS_PER_BIT    (C1),
        .SAMPLE_POINT    (S1),
        .BITS_PER_PACKET (B1)
    ) dut1 (
        .clk              (clk),
        .n_rst            (n_rst),
        .enable_timer     (en1),
`ifdef RX_TIMER_RUNTIME_CFG_EN
        .cfg_clks_per_bit (4'd10),
`endif
        .shift_strobe     (strobe1),
        .packet_done      (done1)
    );

    rx_timer #(
        .CLKS_PER_BIT    (C2),
        .SAMPLE_POINT    (S2),
        .BITS_PER_PACKET (B2)
    ) dut2 (
        .clk              (clk),
        .n_rst            (n_rst),
        .enable_timer     (en2),
`ifdef RX_TIMER_RUNTIME_CFG_EN
        .cfg_clks_per_bit (2'd2),
`endif
        .shift_strobe     (strobe2),
        .packet_done      (done2)
    );

    // Strobe b (1..b_max) lands at k = b*c + s - 1.
    function automatic int exp_strobe(input int k, input int c, input int s, input int b_max);
        return (k >= c && (k % c) == s - 1 && (k / c) <= b_max) ? 1 : 0;
    endfunction

    // packet_done lands one clock after the last strobe.
    function automatic int exp_done(input int k, input int c, input int s, input int b_max);
        return (k == b_max * c + s) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    // Model: k counts edges while enable is high, -1 when idle or in reset.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k1 = -1;
            k2 = -1;
        end else begin
            k1 = en1 ? k1 + 1 : -1;
            k2 = en2 ? k2 + 1 : -1;
        end
    end

    // Per-cycle compare against the model, plus a log of event times.
    always @(negedge clk) begin
        check("strobe1", int'(strobe1), exp_strobe(k1, C1, S1, B1));
        check("done1",   int'(done1),   exp_done(k1, C1, S1, B1));
        check("strobe2", int'(strobe2), exp_strobe(k2, C2, S2, B2));
        check("done2",   int'(done2),   exp_done(k2, C2, S2, B2));
        if (strobe1) sq1.push_back(k1);
        if (done1)   dq1.push_back(k1);
        if (strobe2) sq2.push_back(k2);
        if (done2)   dq2.push_back(k2);
    end

    initial begin
        // Reset held with enable high.
        n_rst = 1'b0;
        en1   = 1'b1;
        en2   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobe", int'(strobe1), 0);
        check("reset_done",   int'(done1),   0);
        n_rst = 1'b1;

        // Full packet with enable held high, then a long quiet tail.
        repeat (130) @(posedge clk);
        #1;
        check("pkt_strobe_count", sq1.size(), 9);
        check("pkt_first_strobe", q_at(sq1, 0), 14);
        check("pkt_second_strobe", q_at(sq1, 1), 24);
        check("pkt_last_strobe",  q_at(sq1, 8), 94);
        check("pkt_done_count",   dq1.size(), 1);
        check("pkt_done_k",       q_at(dq1, 0), 95);

        // Restart, then a one-clock enable drop at k=40.
        en1 = 1'b0;
        @(posedge clk);
        #1;
        en1 = 1'b1;
        sq1.delete();
        dq1.delete();
        repeat (41) @(posedge clk);
        #1;
        en1 = 1'b0;
        check("drop_strobe_count", sq1.size(), 3);
        check("drop_last_strobe",  q_at(sq1, 2), 34);
        check("drop_done_count",   dq1.size(), 0);
        @(posedge clk);
        #1;
        en1 = 1'b1;
        sq1.delete();
        dq1.delete();
        repeat (130) @(posedge clk);
        #1;
        check("reen_strobe_count", sq1.size(), 9);
        check("reen_first_strobe", q_at(sq1, 0), 14);
        check("reen_last_strobe",  q_at(sq1, 8), 94);
        check("reen_done_k",       q_at(dq1, 0), 95);

        // Minimal configuration: 2 clocks per bit, sample at 2, one bit.
        en1 = 1'b0;
        en2 = 1'b1;
        sq2.delete();
        dq2.delete();
        repeat (12) @(posedge clk);
        #1;
        check("min_strobe_count", sq2.size(), 1);
        check("min_strobe_k",     q_at(sq2, 0), 3);
        check("min_done_count",   dq2.size(), 1);
        check("min_done_k",       q_at(dq2, 0), 4);
        en2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
